mii_byte_tx: RTL and testbench

//  Byte-stream to MII transmit framer: accepts frame bytes over a valid/ready handshake, emits

---
 rtl/mii_byte_tx_pkg.sv | 39 +++
 rtl/mii_byte_tx.sv | 169 ++++++++++++++++
 tb/tb_mii_byte_tx.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mii_byte_tx_pkg.sv
// Shared types and constants for the MII byte-stream transmit framer.
// Nibble values, default timing and FSM encoding live here.
package mii_byte_tx_pkg;

    localparam logic [3:0] MII_PREAMBLE_NIBBLE  = 4'h5;
    localparam logic [3:0] MII_SFD_NIBBLE       = 4'hD;
    localparam int         MII_PREAMBLE_NIBBLES = 15;
    localparam int         MII_IPG_NIBBLES      = 24;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DATA_LO  = 3'd2,
        ST_DATA_HI  = 3'd3,
        ST_END      = 3'd4,
        ST_IPG      = 3'd5,
        ST_DRAIN    = 3'd6
    } state_t;

    typedef struct packed {
        logic       en;
        logic       er;
        logic [3:0] d;
    } mii_tx_t;

    // In DRAIN the last bit records that the source delivered its last byte.
    typedef struct packed {
        logic [3:0] hi;
        logic       err;
        logic       last;
    } hold_t;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/mii_byte_tx.sv
// Byte-stream to MII transmit framer: preamble/SFD insertion,
// nibble serialisation, inter-frame gap and underrun signalling.
module mii_byte_tx
    import mii_byte_tx_pkg::*;
#(
    parameter int PREAMBLE_NIBBLES = MII_PREAMBLE_NIBBLES,
    parameter int IPG_NIBBLES      = MII_IPG_NIBBLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [7:0] data,
    input  logic       valid,
    input  logic       last,
    input  logic       err,
    output logic       ready,
    output logic       tx_en,
    output logic       tx_er,
    output logic [3:0] txd,
    output logic       underflow
);

    localparam int CW = cnt_width(PREAMBLE_NIBBLES, IPG_NIBBLES);
    localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_NIBBLES);
    localparam logic [CW-1:0] IPG_LAST = CW'(IPG_NIBBLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    hold_t         hold;
    hold_t         hold_nx;
    mii_tx_t       tx;
    mii_tx_t       tx_nx;
    logic          underflow_nx;
    logic          accept;
    logic          drain_done;

    assign ready = (state == ST_DRAIN) ||
                   (state == ST_DATA_LO && ce);

    assign accept = valid && ready;

    // Drain ends once the source has flushed its frame and the gap is met.
    assign drain_done = (hold.last || (accept && last)) &&
                        (cnt == IPG_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (ce && valid) state_nx = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                if (ce && cnt >= PRE_LAST) state_nx = ST_DATA_LO;
            end
            ST_DATA_LO: begin
                if (ce) state_nx = valid ? ST_DATA_HI : ST_DRAIN;
            end
            ST_DATA_HI: begin
                if (ce) state_nx = hold.last ? ST_END : ST_DATA_LO;
            end
            ST_END: begin
                if (ce) state_nx = ST_IPG;
            end
            ST_IPG: begin
                if (ce && cnt == IPG_LAST) state_nx = ST_IDLE;
            end
            ST_DRAIN: begin
                if (drain_done) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_nx        = tx;
        cnt_nx       = cnt;
        hold_nx      = hold;
        underflow_nx = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (ce && valid) begin
                    tx_nx = '{en: 1'b1, er: 1'b0,
                              d: MII_PREAMBLE_NIBBLE};
                    cnt_nx = CNT_ONE;
                end
            end
            ST_PREAMBLE: begin
                if (ce) begin
                    if (cnt < PRE_LAST) begin
                        tx_nx.d = MII_PREAMBLE_NIBBLE;
                        cnt_nx  = cnt + CNT_ONE;
                    end else begin
                        tx_nx.d = MII_SFD_NIBBLE;
                        cnt_nx  = '0;
                    end
                end
            end
            ST_DATA_LO: begin
                if (ce && valid) begin
                    tx_nx.d  = data[3:0];
                    tx_nx.er = err;
                    hold_nx  = '{hi: data[7:4], err: err, last: last};
                end else if (ce) begin
                    tx_nx        = '{en: 1'b1, er: 1'b1, d: 4'h0};
                    underflow_nx = 1'b1;
                    cnt_nx       = '0;
                    hold_nx      = '0;
                end
            end
            ST_DATA_HI: begin
                if (ce) begin
                    tx_nx.d  = hold.hi;
                    tx_nx.er = hold.err;
                end
            end
            ST_END: begin
                if (ce) begin
                    tx_nx  = '0;
                    cnt_nx = CNT_ONE;
                end
            end
            ST_IPG: begin
                if (ce && cnt != IPG_LAST) cnt_nx = cnt + CNT_ONE;
            end
            ST_DRAIN: begin
                if (accept && last) hold_nx.last = 1'b1;
                // First ce ends the error nibble; gap counts from there.
                if (ce) begin
                    tx_nx = '0;
                    if (cnt < IPG_LAST) cnt_nx = cnt + CNT_ONE;
                end
            end
            default: begin
                tx_nx  = '0;
                cnt_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx        <= '0;
            cnt       <= '0;
            hold      <= '0;
            underflow <= 1'b0;
        end else begin
            tx        <= tx_nx;
            cnt       <= cnt_nx;
            hold      <= hold_nx;
            underflow <= underflow_nx;
        end
    end

    assign tx_en = tx.en;
    assign tx_er = tx.er;
    assign txd   = tx.d;

endmodule

// File: tb/tb_mii_byte_tx.sv
// Directed bench for mii_byte_tx: framing, ce pacing, underrun,
// error bytes, back-to-back gap and mid-frame reset.
module tb_mii_byte_tx;

    localparam int PRE = 15;
    localparam int IPG = 24;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce = 1'b1;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       last = 1'b0;
    logic       err = 1'b0;
    logic       ready;
    logic       tx_en;
    logic       tx_er;
    logic [3:0] txd;
    logic       underflow;

    int checks = 0;
    int errors = 0;
    int ce_div = 1;
    int phase = 0;
    logic rdy_seen;

    logic [5:0] log_q[$];
    logic [5:0] exp_q[$];
    logic [5:0] prev = '0;
    logic       ce_at;
    logic       rst_at;
    logic       chk_rdy = 1'b0;
    int         holdv = 0;
    int         rnc = 0;

    mii_byte_tx #(
        .PREAMBLE_NIBBLES(PRE),
        .IPG_NIBBLES(IPG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ce(ce),
        .data(data),
        .valid(valid),
        .last(last),
        .err(err),
        .ready(ready),
        .tx_en(tx_en),
        .tx_er(tx_er),
        .txd(txd),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ce_at = ce;
        rst_at = rst;
        if (chk_rdy && ready && !ce) rnc++;
        #1;
        if (ce_at) log_q.push_back({tx_en, tx_er, txd});
        else if (!rst_at && {tx_en, tx_er, txd} !== prev) holdv++;
        prev = {tx_en, tx_er, txd};
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        ce = (ce_div <= 1) || (phase == 0);
        phase = (phase + 1) % ce_div;
        #1;
        rdy_seen = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid = 1'b0;
        wait_n(2);
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l,
                             input logic e, output int n);
        data = b;
        last = l;
        err = e;
        valid = 1'b1;
        n = 0;
        rdy_seen = 1'b0;
        while (!rdy_seen && n < 300) begin
            cyc();
            n++;
        end
        chk("accept", int'(rdy_seen), 1);
    endtask

    task automatic add_pre();
        for (int i = 0; i < PRE; i++) exp_q.push_back(6'b10_0101);
        exp_q.push_back(6'b10_1101);
    endtask

    task automatic add_byte(input logic [7:0] b, input logic e);
        exp_q.push_back({1'b1, e, b[3:0]});
        exp_q.push_back({1'b1, e, b[7:4]});
    endtask

    function automatic int find_en(input int from, input logic v);
        if (from < 0) return -1;
        for (int i = from; i < log_q.size(); i++)
            if (log_q[i][5] == v) return i;
        return -1;
    endfunction

    task automatic chk_frame(input string tag, input int from,
                             output int nxt);
        int s;
        int bad;
        s = find_en(from, 1'b1);
        bad = 0;
        if (s < 0) begin
            bad = 1000;
            nxt = -1;
        end else begin
            for (int i = 0; i < exp_q.size(); i++)
                if (s + i >= log_q.size() || log_q[s+i] !== exp_q[i])
                    bad++;
            nxt = s + exp_q.size();
        end
        chk({tag, "_nibbles"}, bad, 0);
        chk({tag, "_end"},
            (nxt >= 0 && nxt < log_q.size()) ? int'(log_q[nxt]) : -1, 0);
        exp_q.delete();
    endtask

    initial begin
        int n;
        int m;
        int f;
        int r;
        int ers;

        // reset state
        do_reset();
        chk("rst_tx_en", int'(tx_en), 0);
        chk("rst_tx_er", int'(tx_er), 0);
        chk("rst_txd", int'(txd), 0);
        chk("rst_underflow", int'(underflow), 0);
        chk("rst_ready", int'(ready), 0);

        // ce=1, {12,34 last} then back-to-back single byte 56
        m = log_q.size();
        send_byte(8'h12, 1'b0, 1'b0, n);
        send_byte(8'h34, 1'b1, 1'b0, n);
        send_byte(8'h56, 1'b1, 1'b0, n);
        valid = 1'b0;
        wait_n(40);
        add_pre();
        add_byte(8'h12, 1'b0);
        add_byte(8'h34, 1'b0);
        chk_frame("t1_f1", m, f);
        r = find_en(f, 1'b1);
        chk("t1_gap", r - f - 1, IPG);
        add_pre();
        add_byte(8'h56, 1'b0);
        chk_frame("t1_f2", r, f);

        // ce 1-in-3, same frame
        do_reset();
        ce_div = 3;
        phase = 0;
        m = log_q.size();
        holdv = 0;
        chk_rdy = 1'b1;
        send_byte(8'h12, 1'b0, 1'b0, n);
        send_byte(8'h34, 1'b1, 1'b0, n);
        valid = 1'b0;
        wait_n(30);
        chk_rdy = 1'b0;
        add_pre();
        add_byte(8'h12, 1'b0);
        add_byte(8'h34, 1'b0);
        chk_frame("t2_frame", m, f);
        chk("t2_hold_between_ce", holdv, 0);
        chk("t2_ready_without_ce", rnc, 0);
        ce_div = 1;
        phase = 0;

        // underrun before byte 2
        do_reset();
        m = log_q.size();
        send_byte(8'h12, 1'b0, 1'b0, n);
        valid = 1'b0;
        n = 0;
        while (!underflow && n < 10) begin
            cyc();
            n++;
        end
        chk("t3_underflow", int'(underflow), 1);
        chk("t3_err_en", int'(tx_en), 1);
        chk("t3_err_er", int'(tx_er), 1);
        chk("t3_err_txd", int'(txd), 0);
        send_byte(8'h55, 1'b0, 1'b0, n);
        chk("t3_drain_rdy1", n, 1);
        chk("t3_uf_pulse", int'(underflow), 0);
        chk("t3_en_fall", int'(tx_en), 0);
        send_byte(8'h66, 1'b1, 1'b0, n);
        chk("t3_drain_rdy2", n, 1);
        valid = 1'b0;
        wait_n(30);
        send_byte(8'h77, 1'b1, 1'b0, n);
        valid = 1'b0;
        wait_n(30);
        add_pre();
        add_byte(8'h12, 1'b0);
        exp_q.push_back(6'b11_0000);
        chk_frame("t3_bad", m, f);
        ers = 0;
        for (int i = m; i < log_q.size(); i++)
            if (log_q[i][4]) ers++;
        chk("t3_er_count", ers, 1);
        r = find_en(f, 1'b1);
        chk("t3_gap_min", int'((r - f - 1) >= IPG), 1);
        add_pre();
        add_byte(8'h77, 1'b0);
        chk_frame("t3_next", r, f);

        // err byte mid-frame, then last&&err single-byte frame
        do_reset();
        m = log_q.size();
        send_byte(8'h12, 1'b0, 1'b0, n);
        send_byte(8'hAB, 1'b0, 1'b1, n);
        send_byte(8'h34, 1'b1, 1'b0, n);
        send_byte(8'hC3, 1'b1, 1'b1, n);
        valid = 1'b0;
        wait_n(30);
        add_pre();
        add_byte(8'h12, 1'b0);
        add_byte(8'hAB, 1'b1);
        add_byte(8'h34, 1'b0);
        chk_frame("t4_f1", m, f);
        r = find_en(f, 1'b1);
        chk("t4_gap", r - f - 1, IPG);
        add_pre();
        add_byte(8'hC3, 1'b1);
        chk_frame("t4_f2", r, f);

        // reset in DATA_HI, new frame without gap
        do_reset();
        send_byte(8'h12, 1'b0, 1'b0, n);
        rst = 1'b1;
        valid = 1'b0;
        cyc();
        chk("t6_rst_en", int'(tx_en), 0);
        chk("t6_rst_er", int'(tx_er), 0);
        chk("t6_rst_txd", int'(txd), 0);
        rst = 1'b0;
        m = log_q.size();
        data = 8'h9A;
        last = 1'b1;
        err = 1'b0;
        valid = 1'b1;
        cyc();
        chk("t6_start_en", int'(tx_en), 1);
        chk("t6_start_txd", int'(txd), 5);
        send_byte(8'h9A, 1'b1, 1'b0, n);
        valid = 1'b0;
        wait_n(20);
        add_pre();
        add_byte(8'h9A, 1'b0);
        chk_frame("t6_frame", m, f);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
